// File: rtl/sm4_keyex.sv
// sm4_keyex -- SM4 key-expansion engine.
// Expands a 128-bit master key into round keys rk0..rk31 at one round key per
// clock. The S-box is borrowed: o_sbox_din goes out, i_sbox_dout comes back
// combinationally in the same cycle.
// Build option: define SM4_KEYEX_RESTART_EN to let a start strobe that arrives
// during a running schedule restart it with the new key. Without the macro,
// such a strobe is ignored and the running schedule completes.
module sm4_keyex (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [127:0]  i_key,
  input  logic          i_key_en,
  output logic [1023:0] o_keyex,
  output logic          o_keyex_en,
  output logic          o_busy,
  output logic [31:0]   o_sbox_din,
  input  logic [31:0]   i_sbox_dout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

`ifdef SM4_KEYEX_RESTART_EN
  localparam logic RESTART_EN = 1'b1;
`else
  localparam logic RESTART_EN = 1'b0;
`endif

  // K0 lives in [127:96] and K3 in [31:0], so one round is a single left shift.
  state_e          state_q, state_d;
  logic [127:0]    k_q, k_d;
  logic [4:0]      r_count_q, r_count_d;
  logic [1023:0]   keyex_q, keyex_d;
  logic            keyex_en_q, keyex_en_d;
  logic [31:0]     sbox_din;
  logic [31:0]     rk;

  // CK_i byte j = (4i + j) * 7 mod 256. Eight-bit arithmetic does the modulo.
  function automatic logic [31:0] ck_word(input logic [4:0] idx);
    logic [31:0] ck;
    logic [7:0]  n;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      n = {1'b0, idx, 2'(j)};
      ck[31-8*j -: 8] = n * 8'd7;
    end
    return ck;
  endfunction

  // Key-schedule linear transform L'(B) = B ^ (B <<< 13) ^ (B <<< 23).
  function automatic logic [31:0] l_prime(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Next-state logic: load on start, one round per RUN cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    r_count_d  = r_count_q;
    keyex_d    = keyex_q;
    keyex_en_d = 1'b0;
    sbox_din   = '0;
    rk         = k_q[127:96] ^ l_prime(i_sbox_dout);

    case (state_q)
      S_IDLE: begin
        if (i_key_en) begin
          state_d   = S_RUN;
          k_d       = i_key ^ FK;
          r_count_d = '0;
        end
      end

      S_RUN: begin
        sbox_din = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck_word(r_count_q);
        if (RESTART_EN && i_key_en) begin
          // Abandon the current schedule; the aborted key never reports.
          k_d       = i_key ^ FK;
          r_count_d = '0;
        end else begin
          k_d       = {k_q[95:0], rk};
          keyex_d   = {keyex_q[991:0], rk};
          r_count_d = r_count_q + 5'd1;
          if (r_count_q == 5'd31) begin
            state_d    = S_IDLE;
            keyex_en_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      r_count_q  <= '0;
      keyex_q    <= '0;
      keyex_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      r_count_q  <= r_count_d;
      keyex_q    <= keyex_d;
      keyex_en_q <= keyex_en_d;
    end
  end

  assign o_keyex    = keyex_q;
  assign o_keyex_en = keyex_en_q;
  assign o_busy     = (state_q == S_RUN);
  assign o_sbox_din = sbox_din;

endmodule

// File: tb/tb_sm4_keyex.sv
// tb_sm4_keyex -- scoreboard bench for sm4_keyex.
// Provides the external S-box, issues known-answer, back-to-back, mid-run
// strobe, reset-abort and random keys, and compares every o_keyex_en result
// (data and arrival cycle) against a reference key schedule.
module tb_sm4_keyex;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [127:0]  i_key = '0;
  logic          i_key_en = 1'b0;
  logic [1023:0] o_keyex;
  logic          o_keyex_en;
  logic          o_busy;
  logic [31:0]   o_sbox_din;
  logic [31:0]   i_sbox_dout;

  always #5 i_clk = ~i_clk;

  sm4_keyex dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_key       (i_key),
    .i_key_en    (i_key_en),
    .o_keyex     (o_keyex),
    .o_keyex_en  (o_keyex_en),
    .o_busy      (o_busy),
    .o_sbox_din  (o_sbox_din),
    .i_sbox_dout (i_sbox_dout)
  );

`ifdef SM4_KEYEX_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  localparam logic [127:0] FK_C  = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [127:0] KAT_K = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  logic [0:2047] sbox_flat = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef struct {
    logic [1023:0] keys;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            fails = 0;
  int            cyc = 0;
  int            t_start = 0;
  logic [1023:0] last_keys = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_flat[int'(x)*8 +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [31:0] ck(input int i);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
    return r;
  endfunction

  // K_n of the schedule: K0..K3 = MK ^ FK, K_{i+4} = K_i ^ L'(tau(...)).
  function automatic logic [31:0] kword(input logic [127:0] mk, input int n);
    logic [31:0]  k [36];
    logic [31:0]  b;
    logic [127:0] fk;
    fk = FK_C;
    for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ fk[127-32*j -: 32];
    for (int i = 0; i < 32; i++) begin
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i));
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
    end
    return k[n];
  endfunction

  function automatic logic [1023:0] ref_keys(input logic [127:0] mk);
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[1023-32*i -: 32] = kword(mk, i + 4);
    return r;
  endfunction

  // SM4 data path, used to prove the produced schedule works end to end.
  function automatic logic [127:0] sm4_crypt(input logic [127:0] din,
                                             input logic [1023:0] keys,
                                             input bit dec);
    logic [31:0] x [36];
    logic [31:0] b;
    logic [31:0] rk;
    int          r;
    for (int j = 0; j < 4; j++) x[j] = din[127-32*j -: 32];
    for (int i = 0; i < 32; i++) begin
      r  = dec ? 31 - i : i;
      rk = keys[1023-32*r -: 32];
      b  = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk);
      x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // External combinational S-box.
  always_comb i_sbox_dout = tau(o_sbox_din);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_keys(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      for (int i = 0; i < 32; i++) begin
        if (act[1023-32*i -: 32] !== exp[1023-32*i -: 32]) begin
          $display("FAIL %s rk%0d got=%h expected=%h (cycle %0d)", name, i,
                   act[1023-32*i -: 32], exp[1023-32*i -: 32], cyc);
          break;
        end
      end
    end
  endtask

  // Monitor: every o_keyex_en pulse must match the oldest expected result.
  always @(negedge i_clk) begin
    if (o_keyex_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_keyex_en at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_keys("keyex_data", o_keyex, e.keys);
        check("keyex_en_cycle", 128'(cyc), 128'(e.cyc));
        last_keys = o_keyex;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic [127:0] key, input bit do_push);
    exp_t e;
    @(posedge i_clk); #1;
    i_key    = key;
    i_key_en = 1'b1;
    t_start  = cyc;
    if (do_push) begin
      e.keys = ref_keys(key);
      e.cyc  = cyc + 33;
      sb_q.push_back(e);
    end
    @(posedge i_clk); #1;
    i_key_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (sb_q.size() != 0 || o_busy); i++) @(posedge i_clk);
    repeat (2) @(posedge i_clk);
    check("drain_pending", 128'(sb_q.size()), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_keyex"},    o_keyex[127:0] | o_keyex[1023:896], 128'd0);
    check({tag, "_keyex_en"}, 128'(o_keyex_en), 128'd0);
    check({tag, "_busy"},     128'(o_busy), 128'd0);
    check({tag, "_sbox_din"}, 128'(o_sbox_din), 128'd0);
  endtask

  initial begin
    logic [127:0] k1, k2;
    logic [31:0]  w1, w2, w3;

    // Reset with a start strobe held high: reset must win.
    i_key    = KAT_K;
    i_key_en = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    i_key_en = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Known-answer key, with S-box feed and busy timing checks.
    start(KAT_K, 1'b1);
    @(negedge i_clk);
    check("busy_first_round", 128'(o_busy), 128'd1);
    w1 = kword(KAT_K, 1); w2 = kword(KAT_K, 2); w3 = kword(KAT_K, 3);
    check("sbox_din_round0", 128'(o_sbox_din), 128'(w1 ^ w2 ^ w3 ^ 32'h00070E15));
    repeat (31) @(posedge i_clk);
    @(negedge i_clk);
    check("busy_last_round", 128'(o_busy), 128'd1);
    w1 = kword(KAT_K, 32); w2 = kword(KAT_K, 33); w3 = kword(KAT_K, 34);
    check("sbox_din_round31", 128'(o_sbox_din), 128'(w1 ^ w2 ^ w3 ^ 32'h646B7279));
    @(negedge i_clk);
    check("keyex_en_pulse", 128'(o_keyex_en), 128'd1);
    check("busy_after_run", 128'(o_busy), 128'd0);
    check("sbox_din_idle", 128'(o_sbox_din), 128'd0);
    @(negedge i_clk);
    check("keyex_en_single", 128'(o_keyex_en), 128'd0);
    check("kat_rk0",  128'(last_keys[1023:992]), 128'h F12186F9);
    check("kat_rk1",  128'(last_keys[991:960]),  128'h41662B61);
    check("kat_rk31", 128'(last_keys[31:0]),     128'h9124A012);
    check("loopback_encrypt", sm4_crypt(KAT_K, last_keys, 1'b0),
          128'h681EDF34_D206965E_86B3E94F_536E4246);
    check("loopback_decrypt",
          sm4_crypt(128'h681EDF34_D206965E_86B3E94F_536E4246, last_keys, 1'b1), KAT_K);
    wait_drain();

    // Back-to-back: second strobe lands in the o_keyex_en cycle.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start(k1, 1'b1);
    repeat (31) @(posedge i_clk);
    start(k2, 1'b1);
    @(negedge i_clk);
    check_keys("b2b_hold_first", o_keyex, ref_keys(k1));
    check("b2b_busy", 128'(o_busy), 128'd1);
    wait_drain();

    // Strobe at RUN cycle 10.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start(k1, !RESTART);
    repeat (9) @(posedge i_clk);
    start(k2, RESTART);
    @(negedge i_clk);
    check("midrun_busy", 128'(o_busy), 128'd1);
    wait_drain();

    // Reset at RUN cycle 20 aborts the run; nothing is queued for it.
    start({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (19) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("abort");
    repeat (40) @(posedge i_clk);
    start({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_drain();

    // Random keys, randomly back-to-back or spaced out.
    for (int i = 0; i < 6; i++) begin
      start({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      if (i < 5 && $urandom_range(0, 1) == 1) begin
        repeat (31) @(posedge i_clk);
      end else begin
        wait_drain();
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
      end
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
